serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Parametrised, digit-serial successor to the 1-bit full subtractor.
- Computes Diff = A − B − Bin on WIDTH-bit operands, DIGIT bits per clock, carrying a registered borrow between cycles.
- Produces the final borrow-out and a signed-overflow flag.
- Sits between a valid/ready producer and consumer. One operation is in flight at a time.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 1.
- DIGIT, 2, bits processed per clock. 1 ≤ DIGIT ≤ WIDTH, and WIDTH % DIGIT must equal 0, else elaboration error.
- NSTEP, WIDTH/DIGIT, derived localparam, not overridable. Number of compute cycles per operation.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  A − B − Bin, modulo 2^WIDTH
- bout  output  1  final borrow-out: 1 iff unsigned A < B + Bin
- ovf  output  1  signed overflow: two's-complement A − B − Bin is not representable in WIDTH bits

Behaviour:
- Reset: asynchronous on rst_n low, released synchronously.
  - State goes to IDLE.
  - in_ready=1, out_valid=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow register and step counter are cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b and bin (bin goes into the borrow register), clear the counter, go to RUN.
- RUN:
  - in_ready=0. in_valid is ignored.
  - Each cycle, the DIGIT LSBs of the A and B shift registers plus the borrow register produce a DIGIT-bit difference digit and a new borrow.
  - The digit is shifted into the diff register from the MSB end. The operand registers shift right by DIGIT. The counter increments.
  - After the NSTEP-th compute edge:
    - Register bout = final borrow.
    - Register ovf = borrow into the MSB XOR borrow out of the MSB. The borrow into the MSB is taken inside the last digit.
    - Go to DONE.
- DONE:
  - out_valid=1. diff, bout and ovf are stable.
  - While out_ready=0, all outputs hold and in_valid is ignored.
  - On out_ready=1: go to IDLE and drop out_valid on the next edge. diff, bout and ovf keep their last values until the next operation completes.
- Latency: accept edge plus NSTEP compute edges.
  - out_valid is first seen high NSTEP cycles after the accept edge.
  - Throughput is one operation per NSTEP+2 cycles with no back-pressure.
- DIGIT=WIDTH degenerates to one compute cycle. This must work.
- WIDTH=1, DIGIT=1 must reproduce the 1-bit full-subtractor truth table.
- Reset asserted mid-RUN or in DONE aborts the operation immediately and returns to reset values. No partial result is ever flagged valid.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Shared package holds the FSM state typedef (IDLE/RUN/DONE) and the step-counter width function, clog2 of NSTEP+1.
- One natural sub-module is sub_digit: combinational, DIGIT-wide ripple of 1-bit full-subtractor cells. Inputs a_d, b_d, bi. Outputs d, bo, and b_msb_in (borrow into the top bit, used for ovf).
- The top level owns the FSM, counter and shift registers.

Test Plan:
- WIDTH=8, DIGIT=2: a=0x05, b=0x03, bin=0 accepted → out_valid high 4 cycles later; diff=0x02, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF, bin=0 → diff=0x80, bout=1, ovf=1.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid with new operands → outputs unchanged, in_ready=0, no second accept. Release out_ready → IDLE, in_ready=1.
- Pull rst_n low for one cycle in the 2nd RUN cycle → immediate IDLE, all outputs 0, out_valid never asserted for that operation. A following op a=0x10, b=0x01 gives 0x0F.
- Sweep configurations (WIDTH,DIGIT) = (1,1), (8,1), (8,8), (16,4) with 1000 random a/b/bin each, checked against a reference model of A − B − Bin (diff, bout, ovf). Also cover the WIDTH=1 exhaustive truth table of 8 cases.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state type and step-counter sizing for the digit-serial subtractor
package serial_subtractor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(int nstep);
    return $clog2(nstep + 1);
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result valid-ready bus between producer, subtractor and consumer
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, ovf);
  modport slave  (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor_sub_digit.sv
// sub_digit: DIGIT-wide ripple of 1-bit full-subtractor cells, exposing the borrow into the top bit
module sub_digit #(parameter int DIGIT = 2) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo,
  output logic             b_msb_in
);
  logic [DIGIT:0] br;
  assign br[0] = bi;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]    = a_d[i] ^ b_d[i] ^ br[i];
    assign br[i+1] = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & br[i]);
  end
  assign bo       = br[DIGIT];
  assign b_msb_in = br[DIGIT-1];
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial A - B - Bin with registered borrow, borrow-out and signed overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave s
);
  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = cnt_w(NSTEP);
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad
    $error("serial_subtractor: invalid WIDTH/DIGIT");
  end
  state_t           state;
  logic [WIDTH-1:0] ra, rb, rd, rd_nx, dw, diff_q;
  logic [CW-1:0]    cnt;
  logic             br, bout_q, ovf_q, rdy_q, vld_q;
  logic [DIGIT-1:0] d;
  logic             bo, bm, last;
  sub_digit #(.DIGIT(DIGIT)) u_dig (
    .a_d(ra[DIGIT-1:0]), .b_d(rb[DIGIT-1:0]), .bi(br), .d(d), .bo(bo), .b_msb_in(bm)
  );
  // each new digit enters at the MSB so the LSB digit lands at bit 0 after NSTEP shifts
  assign dw    = WIDTH'(d);
  assign rd_nx = (rd >> DIGIT) | (dw << (WIDTH - DIGIT));
  assign last  = cnt == CW'(NSTEP - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rd     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s.in_valid && rdy_q) begin
          ra    <= s.a;
          rb    <= s.b;
          br    <= s.bin;
          cnt   <= '0;
          rdy_q <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          ra  <= ra >> DIGIT;
          rb  <= rb >> DIGIT;
          rd  <= rd_nx;
          br  <= bo;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff_q <= rd_nx;
            bout_q <= bo;
            ovf_q  <= bo ^ bm;
            vld_q  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: if (s.out_ready) begin
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign s.in_ready  = rdy_q;
  assign s.out_valid = vld_q;
  assign s.diff      = diff_q;
  assign s.bout      = bout_q;
  assign s.ovf       = ovf_q;
endmodule
